// File: rtl/dmem_dual_port_arbiter.sv
// Memory-stage arbiter for the dual-issue pipeline: serialises two lanes onto a
// single-port data memory (lane 1 first) and handles sub-word placement/extension.
module dmem_dual_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM1,
  input  logic        MemWriteM1,
  input  logic [2:0]  Funct3M1,
  input  logic [31:0] ALUResultM1,
  input  logic [31:0] WriteDataM1,
  input  logic        MemReadM2,
  input  logic        MemWriteM2,
  input  logic [2:0]  Funct3M2,
  input  logic [31:0] ALUResultM2,
  input  logic [31:0] WriteDataM2,
  output logic [31:0] DMemAddr,
  output logic        DMemWE,
  output logic [3:0]  DMemBE,
  output logic [31:0] DMemWD,
  input  logic [31:0] DMemRD,
  output logic [31:0] ReadDataM1,
  output logic [31:0] ReadDataM2,
  output logic        StallMem,
  output logic        MisalignM1,
  output logic        MisalignM2
);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t      state;
  logic [31:0] hold_q;

  // Size is carried by funct3[1:0]: 00 byte, 01 half, anything else word.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wd(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  logic        req1, req2, act1, act2;
  logic        load1, load2, store1, store2;
  logic [31:0] ld_data1, ld_data2;
  logic        drive_lane2, dual;

  assign req1 = MemReadM1 | MemWriteM1;
  assign req2 = MemReadM2 | MemWriteM2;

  assign MisalignM1 = req1 & misaligned(Funct3M1, ALUResultM1[1:0]);
  assign MisalignM2 = req2 & misaligned(Funct3M2, ALUResultM2[1:0]);

  assign act1 = req1 & ~MisalignM1;
  assign act2 = req2 & ~MisalignM2;

  // Read+write together counts as a store, so a load requires write low.
  assign store1 = MemWriteM1 & ~MisalignM1;
  assign store2 = MemWriteM2 & ~MisalignM2;
  assign load1  = MemReadM1 & ~MemWriteM1 & ~MisalignM1;
  assign load2  = MemReadM2 & ~MemWriteM2 & ~MisalignM2;

  assign ld_data1 = load1 ? load_extract(Funct3M1, ALUResultM1[1:0], DMemRD) : 32'h0;
  assign ld_data2 = load2 ? load_extract(Funct3M2, ALUResultM2[1:0], DMemRD) : 32'h0;

  assign dual        = act1 & act2;
  assign drive_lane2 = (state == SECOND) || (!act1 && act2);

  // NOTE: every output gets a default before the branch so no latch is inferred.
  always_comb begin
    DMemAddr   = {ALUResultM1[31:2], 2'b00};
    DMemWE     = store1;
    DMemBE     = 4'b0000;
    DMemWD     = store_wd(Funct3M1, WriteDataM1);
    ReadDataM1 = ld_data1;
    ReadDataM2 = 32'h0;
    StallMem   = (state == IDLE) && dual;
    if (store1) DMemBE = store_be(Funct3M1, ALUResultM1[1:0]);
    if (drive_lane2) begin
      DMemAddr   = {ALUResultM2[31:2], 2'b00};
      DMemWE     = store2;
      DMemBE     = store2 ? store_be(Funct3M2, ALUResultM2[1:0]) : 4'b0000;
      DMemWD     = store_wd(Funct3M2, WriteDataM2);
      ReadDataM2 = ld_data2;
    end
    if (state == SECOND) ReadDataM1 = hold_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      hold_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (dual) begin
            hold_q <= ld_data1;
            state  <= SECOND;
          end
        end
        SECOND:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
